// File: rtl/axi_dw_txn_regulator.sv
// Outstanding-burst regulator in front of the AXI data-width converter.
// It gates only the AW/AR handshakes, counts completions and offers a drain/halt handshake.
module axi_dw_txn_regulator #(
  parameter int MAX_WRITES = 8,
  parameter int MAX_READS  = 8,
  parameter int CNT_W      = $clog2(((MAX_WRITES > MAX_READS) ? MAX_WRITES : MAX_READS) + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             slv_aw_awvalid,
  output logic             slv_aw_awready,
  output logic             mst_aw_awvalid,
  input  logic             mst_aw_awready,
  input  logic             slv_ar_arvalid,
  output logic             slv_ar_arready,
  output logic             mst_ar_arvalid,
  input  logic             mst_ar_arready,
  input  logic             mst_b_bvalid,
  input  logic             mst_b_bready,
  input  logic             mst_r_rvalid,
  input  logic             mst_r_rready,
  input  logic             mst_r_rlast,
  input  logic             drain_req_i,
  output logic             drain_ack_o,
  output logic [CNT_W-1:0] wr_cnt_o,
  output logic [CNT_W-1:0] rd_cnt_o,
  output logic             err_o
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  localparam logic [CNT_W-1:0] WR_LIM = CNT_W'(MAX_WRITES);
  localparam logic [CNT_W-1:0] RD_LIM = CNT_W'(MAX_READS);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic             aw_hold_q, aw_hold_d, ar_hold_q, ar_hold_d;
  logic             err_q, err_d;
  logic             rst_done_q;

  logic allow_w, allow_r;
  logic aw_hs, ar_hs, b_hs, r_done;
  logic wr_under, rd_under, idle;

  // Returns {underflow, next count}; a decrement at zero saturates and flags.
  function automatic logic [CNT_W:0] cnt_step(input logic [CNT_W-1:0] cnt,
                                               input logic inc, input logic dec);
    logic [CNT_W:0] res;
    res = {1'b0, cnt};
    if (inc && !dec) begin
      res = {1'b0, cnt + CNT_W'(1)};
    end else if (dec && !inc) begin
      if (cnt == '0) res = {1'b1, cnt};
      else           res = {1'b0, cnt - CNT_W'(1)};
    end
    return res;
  endfunction

  // A held request keeps its grant so a presented valid is never withdrawn.
  assign allow_w = rst_done_q & (aw_hold_q | ((state_q == ST_RUN) & (wr_cnt_q < WR_LIM)));
  assign allow_r = rst_done_q & (ar_hold_q | ((state_q == ST_RUN) & (rd_cnt_q < RD_LIM)));

  assign mst_aw_awvalid = slv_aw_awvalid & allow_w;
  assign slv_aw_awready = mst_aw_awready & allow_w;
  assign mst_ar_arvalid = slv_ar_arvalid & allow_r;
  assign slv_ar_arready = mst_ar_arready & allow_r;

  assign aw_hs  = mst_aw_awvalid & mst_aw_awready;
  assign ar_hs  = mst_ar_arvalid & mst_ar_arready;
  assign b_hs   = mst_b_bvalid & mst_b_bready;
  assign r_done = mst_r_rvalid & mst_r_rready & mst_r_rlast;

  assign idle = (wr_cnt_q == '0) & (rd_cnt_q == '0) & ~aw_hold_q & ~ar_hold_q & ~aw_hs & ~ar_hs;

  always_comb begin
    {wr_under, wr_cnt_d} = cnt_step(wr_cnt_q, aw_hs, b_hs);
    {rd_under, rd_cnt_d} = cnt_step(rd_cnt_q, ar_hs, r_done);
    err_d     = err_q | wr_under | rd_under | ((state_q == ST_HALT) & (b_hs | r_done));
    aw_hold_d = aw_hs ? 1'b0 : (aw_hold_q | (mst_aw_awvalid & ~mst_aw_awready));
    ar_hold_d = ar_hs ? 1'b0 : (ar_hold_q | (mst_ar_arvalid & ~mst_ar_arready));

    state_d = state_q;
    case (state_q)
      ST_RUN:   if (drain_req_i) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!drain_req_i) state_d = ST_RUN;
        else if (idle)    state_d = ST_HALT;
      end
      ST_HALT:  if (!drain_req_i) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_RUN;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      aw_hold_q  <= 1'b0;
      ar_hold_q  <= 1'b0;
      err_q      <= 1'b0;
      rst_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      aw_hold_q  <= aw_hold_d;
      ar_hold_q  <= ar_hold_d;
      err_q      <= err_d;
      rst_done_q <= 1'b1;
    end
  end

  assign drain_ack_o = (state_q == ST_HALT);
  assign wr_cnt_o    = wr_cnt_q;
  assign rd_cnt_o    = rd_cnt_q;
  assign err_o       = err_q;

`ifndef SYNTHESIS
  // The gating makes counting past the limit impossible.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(aw_hs && !b_hs && wr_cnt_q >= WR_LIM)) else $error("write count overflow");
      assert (!(ar_hs && !r_done && rd_cnt_q >= RD_LIM)) else $error("read count overflow");
    end
  end
`endif

endmodule

// File: tb/tb_axi_dw_txn_regulator.sv
// Self-checking bench: directed scenarios plus random traffic against a
// transaction-level model of outstanding bursts and the drain handshake.
module tb_axi_dw_txn_regulator;
  localparam int MAX_W = 8;
  localparam int MAX_R = 8;
  localparam int CW = $clog2(((MAX_W > MAX_R) ? MAX_W : MAX_R) + 1);

  logic clk, rst_n;
  logic slv_aw_awvalid, slv_aw_awready, mst_aw_awvalid, mst_aw_awready;
  logic slv_ar_arvalid, slv_ar_arready, mst_ar_arvalid, mst_ar_arready;
  logic mst_b_bvalid, mst_b_bready, mst_r_rvalid, mst_r_rready, mst_r_rlast;
  logic drain_req, drain_ack, err;
  logic [CW-1:0] wr_cnt, rd_cnt;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: outstanding counts and a drain mode flag pair.
  bit m_rst_done, m_awh, m_arh, m_err, m_draining, m_halted;
  int m_wr, m_rd;

  axi_dw_txn_regulator #(.MAX_WRITES(MAX_W), .MAX_READS(MAX_R)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .slv_aw_awvalid(slv_aw_awvalid), .slv_aw_awready(slv_aw_awready),
    .mst_aw_awvalid(mst_aw_awvalid), .mst_aw_awready(mst_aw_awready),
    .slv_ar_arvalid(slv_ar_arvalid), .slv_ar_arready(slv_ar_arready),
    .mst_ar_arvalid(mst_ar_arvalid), .mst_ar_arready(mst_ar_arready),
    .mst_b_bvalid(mst_b_bvalid), .mst_b_bready(mst_b_bready),
    .mst_r_rvalid(mst_r_rvalid), .mst_r_rready(mst_r_rready), .mst_r_rlast(mst_r_rlast),
    .drain_req_i(drain_req), .drain_ack_o(drain_ack),
    .wr_cnt_o(wr_cnt), .rd_cnt_o(rd_cnt), .err_o(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rst_done = 0; m_awh = 0; m_arh = 0; m_err = 0;
    m_draining = 0; m_halted = 0; m_wr = 0; m_rd = 0;
  endtask

  // One clock: compare at the falling edge, then advance the model to the rising edge.
  task automatic cycle();
    bit aw_ok, ar_ok, aw_v, ar_v, aw_hs, ar_hs, b_hs, r_hs, quiet;
    @(negedge clk);
    if (!rst_n) model_reset();
    aw_ok = m_rst_done && (m_awh || (!m_draining && !m_halted && m_wr < MAX_W));
    ar_ok = m_rst_done && (m_arh || (!m_draining && !m_halted && m_rd < MAX_R));
    aw_v = slv_aw_awvalid && aw_ok;
    ar_v = slv_ar_arvalid && ar_ok;
    check("mst_awvalid", mst_aw_awvalid, aw_v);
    check("slv_awready", slv_aw_awready, mst_aw_awready && aw_ok);
    check("mst_arvalid", mst_ar_arvalid, ar_v);
    check("slv_arready", slv_ar_arready, mst_ar_arready && ar_ok);
    check("wr_cnt", wr_cnt, m_wr);
    check("rd_cnt", rd_cnt, m_rd);
    check("err", err, m_err);
    check("drain_ack", drain_ack, m_halted);
    if (rst_n) begin
      aw_hs = aw_v && mst_aw_awready;
      ar_hs = ar_v && mst_ar_arready;
      b_hs  = mst_b_bvalid && mst_b_bready;
      r_hs  = mst_r_rvalid && mst_r_rready && mst_r_rlast;
      quiet = m_wr == 0 && m_rd == 0 && !m_awh && !m_arh && !aw_hs && !ar_hs;
      if (m_halted && (b_hs || r_hs)) m_err = 1;
      if (aw_hs && !b_hs) m_wr++;
      else if (b_hs && !aw_hs) begin if (m_wr == 0) m_err = 1; else m_wr--; end
      if (ar_hs && !r_hs) m_rd++;
      else if (r_hs && !ar_hs) begin if (m_rd == 0) m_err = 1; else m_rd--; end
      m_awh = aw_hs ? 0 : (m_awh || (aw_v && !mst_aw_awready));
      m_arh = ar_hs ? 0 : (m_arh || (ar_v && !mst_ar_arready));
      if (m_halted) begin
        if (!drain_req) m_halted = 0;
      end else if (m_draining) begin
        if (!drain_req) m_draining = 0;
        else if (quiet) begin m_draining = 0; m_halted = 1; end
      end else if (drain_req) m_draining = 1;
      m_rst_done = 1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_reset();
    rst_n = 0; drain_req = 0;
    slv_aw_awvalid = 1; mst_aw_awready = 1;
    slv_ar_arvalid = 0; mst_ar_arready = 1;
    mst_b_bvalid = 0; mst_b_bready = 1;
    mst_r_rvalid = 0; mst_r_rready = 1; mst_r_rlast = 0;
    #1;
    // Reset and first pass-through
    repeat (3) cycle();
    check("rst_awvalid", mst_aw_awvalid, 0);
    rst_n = 1;
    cycle();
    #1 check("first_awvalid", mst_aw_awvalid, 1);
    cycle();
    #1 check("wr_after_first", wr_cnt, 1);
    slv_aw_awvalid = 0;

    // Read limit
    slv_ar_arvalid = 1;
    repeat (8) cycle();
    #1 check("rd_at_limit", rd_cnt, 8);
    check("arready_at_limit", slv_ar_arready, 0);
    check("arvalid_at_limit", mst_ar_arvalid, 0);
    mst_r_rvalid = 1; mst_r_rlast = 1;
    cycle();
    mst_r_rvalid = 0; mst_r_rlast = 0;
    #1 check("rd_after_r", rd_cnt, 7);
    check("ar_reopen", mst_ar_arvalid, 1);
    cycle();
    slv_ar_arvalid = 0;
    mst_r_rvalid = 1; mst_r_rlast = 1;
    repeat (8) cycle();
    mst_r_rvalid = 0; mst_r_rlast = 0;

    // Simultaneous AW and B at count 3
    slv_aw_awvalid = 1;
    repeat (2) cycle();
    #1 check("wr_pre_sim", wr_cnt, 3);
    mst_b_bvalid = 1;
    cycle();
    mst_b_bvalid = 0; slv_aw_awvalid = 0;
    #1 check("wr_sim", wr_cnt, 3);
    check("err_sim", err, 0);

    // Drain with a held AW
    mst_b_bvalid = 1;
    repeat (2) cycle();
    mst_b_bvalid = 0;
    mst_aw_awready = 0; slv_aw_awvalid = 1;
    cycle();
    drain_req = 1;
    cycle();
    slv_ar_arvalid = 1;
    repeat (3) begin
      #1 check("held_aw", mst_aw_awvalid, 1);
      check("ar_blocked", mst_ar_arvalid, 0);
      cycle();
    end
    mst_aw_awready = 1;
    cycle();
    slv_aw_awvalid = 0;
    #1 check("wr_held_done", wr_cnt, 2);
    mst_b_bvalid = 1;
    repeat (2) cycle();
    mst_b_bvalid = 0;
    #1 check("ack_not_yet", drain_ack, 0);
    cycle();
    #1 check("drain_ack", drain_ack, 1);
    check("ar_blocked_halt", mst_ar_arvalid, 0);
    drain_req = 0;
    cycle();
    #1 check("ack_drop", drain_ack, 0);
    check("ar_pass", mst_ar_arvalid, 1);
    cycle();
    slv_ar_arvalid = 0;

    // Drain abort with two reads outstanding
    slv_ar_arvalid = 1;
    cycle();
    slv_ar_arvalid = 0;
    #1 check("rd_abort", rd_cnt, 2);
    drain_req = 1;
    cycle();
    repeat (3) begin
      #1 check("abort_no_ack", drain_ack, 0);
      cycle();
    end
    drain_req = 0;
    cycle();
    slv_ar_arvalid = 1;
    #1 check("abort_ar_pass", mst_ar_arvalid, 1);
    slv_ar_arvalid = 0;
    mst_r_rvalid = 1; mst_r_rlast = 1;
    for (int i = 0; i < 20 && m_rd > 0; i++) cycle();
    mst_r_rvalid = 0; mst_r_rlast = 0;

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      slv_aw_awvalid = m_awh ? 1'b1 : 1'($urandom_range(0, 1));
      slv_ar_arvalid = m_arh ? 1'b1 : 1'($urandom_range(0, 1));
      mst_aw_awready = 1'($urandom_range(0, 1));
      mst_ar_arready = 1'($urandom_range(0, 1));
      mst_b_bready   = 1'($urandom_range(0, 1));
      mst_r_rready   = 1'($urandom_range(0, 1));
      mst_b_bvalid   = (m_wr > 0) ? 1'($urandom_range(0, 2) == 0) : 1'b0;
      mst_r_rvalid   = (m_rd > 0) ? 1'($urandom_range(0, 2) == 0) : 1'b0;
      mst_r_rlast    = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) drain_req = ~drain_req;
      cycle();
    end

    // Settle, then underflow error
    drain_req = 0; slv_aw_awvalid = m_awh; slv_ar_arvalid = m_arh;
    mst_aw_awready = 1; mst_ar_arready = 1; mst_b_bready = 1; mst_r_rready = 1;
    mst_r_rvalid = 0; mst_b_bvalid = 0; mst_r_rlast = 1;
    cycle();
    slv_aw_awvalid = 0; slv_ar_arvalid = 0;
    for (int i = 0; i < 40 && (m_wr > 0 || m_rd > 0); i++) begin
      mst_b_bvalid = (m_wr > 0);
      mst_r_rvalid = (m_rd > 0);
      cycle();
    end
    mst_b_bvalid = 0; mst_r_rvalid = 0; mst_r_rlast = 0;
    #1 check("wr_zero", wr_cnt, 0);
    mst_b_bvalid = 1;
    cycle();
    mst_b_bvalid = 0;
    #1 check("wr_underflow", wr_cnt, 0);
    check("err_set", err, 1);
    repeat (3) cycle();
    check("err_sticky", err, 1);
    rst_n = 0;
    #1 check("err_cleared", err, 0);
    cycle();
    rst_n = 1;
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
